// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative multiply/divide engine that owns the HI/LO pair.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   start, op         : launch an operation (accepted only while busy=0)
//                       op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
//   op1, op2          : rs operand / dividend, rt operand / divisor (captured at accept)
//   abort             : squash the in-flight operation (ignored while idle)
//   busy              : an operation is in flight
//   done              : one-cycle completion pulse
//   div_by_zero       : qualifies done for a divide with a zero divisor
//   rd_hi_sel, rdata  : read port, 1 selects HI and 0 selects LO
//
// Multiplies hold busy for MUL_CYCLES cycles and commit on the last busy edge.
// Divides run a restoring divider on operand magnitudes, DIV_BITS_PER_CYCLE
// quotient bits per cycle, followed by one FIX cycle that restores signs.
module muldiv_iter_unit #(
  parameter int XLEN               = 32,
  parameter int MUL_CYCLES         = 4,
  parameter int DIV_BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  input  logic            rd_hi_sel,
  output logic [XLEN-1:0] rdata
);

  localparam int DIV_STEPS = XLEN / DIV_BITS_PER_CYCLE;
  localparam int CNT_W     = $clog2(MUL_CYCLES + DIV_STEPS + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_STEPS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic              dbz_r;
  logic [XLEN-1:0]   hi_r;
  logic [XLEN-1:0]   lo_r;
  logic [2:0]        op_r;
  logic [XLEN-1:0]   a_r;
  logic [XLEN-1:0]   b_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN:0]     rem_r;     // one spare bit: shifted remainder can reach 2*divisor-1
  logic [XLEN-1:0]   quo_r;     // dividend shifts out the top while quotient bits enter at the bottom
  logic [XLEN-1:0]   dvs_r;
  logic              neg_q_r;
  logic              neg_r_r;
  logic              dz_r;

  logic [XLEN-1:0]   mag1_s;
  logic [XLEN-1:0]   mag2_s;
  logic              mul_signed_s;
  logic [2*XLEN-1:0] ext_a_s;
  logic [2*XLEN-1:0] ext_b_s;
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] mul_res_s;
  logic [XLEN:0]     rem_step_s;
  logic [XLEN-1:0]   quo_step_s;
  logic [XLEN-1:0]   quo_fix_s;
  logic [XLEN-1:0]   rem_fix_s;

  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign rdata       = rd_hi_sel ? hi_r : lo_r;

  // Operand magnitudes for the divider; DIVU passes raw values through.
  always_comb begin
    if ((op == OP_DIV) && op1[XLEN-1]) begin
      mag1_s = -op1;
    end else begin
      mag1_s = op1;
    end
    if ((op == OP_DIV) && op2[XLEN-1]) begin
      mag2_s = -op2;
    end else begin
      mag2_s = op2;
    end
  end

  // Full-width product (low 2*XLEN bits of extended operands) and accumulate.
  always_comb begin
    mul_signed_s = (op_r != OP_MULTU);
    if (mul_signed_s) begin
      ext_a_s = {{XLEN{a_r[XLEN-1]}}, a_r};
      ext_b_s = {{XLEN{b_r[XLEN-1]}}, b_r};
    end else begin
      ext_a_s = {{XLEN{1'b0}}, a_r};
      ext_b_s = {{XLEN{1'b0}}, b_r};
    end
    prod_s = ext_a_s * ext_b_s;
    case (op_r)
      OP_MADD: mul_res_s = {hi_r, lo_r} + prod_s;
      OP_MSUB: mul_res_s = {hi_r, lo_r} - prod_s;
      default: mul_res_s = prod_s;
    endcase
  end

  // Restoring divider: DIV_BITS_PER_CYCLE shift/compare/subtract steps per clock.
  always_comb begin
    rem_step_s = rem_r;
    quo_step_s = quo_r;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      rem_step_s = {rem_step_s[XLEN-1:0], quo_step_s[XLEN-1]};
      quo_step_s = {quo_step_s[XLEN-2:0], 1'b0};
      if (rem_step_s >= {1'b0, dvs_r}) begin
        rem_step_s    = rem_step_s - {1'b0, dvs_r};
        quo_step_s[0] = 1'b1;
      end else begin
        quo_step_s[0] = 1'b0;
      end
    end
  end

  // Sign restoration applied in FIX: quotient negative on sign mismatch, remainder follows op1.
  always_comb begin
    if (neg_q_r) begin
      quo_fix_s = -quo_r;
    end else begin
      quo_fix_s = quo_r;
    end
    if (neg_r_r) begin
      rem_fix_s = -rem_r[XLEN-1:0];
    end else begin
      rem_fix_s = rem_r[XLEN-1:0];
    end
  end

  // Control FSM, operand capture, divider iteration and HI/LO commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      dbz_r   <= 1'b0;
      hi_r    <= {XLEN{1'b0}};
      lo_r    <= {XLEN{1'b0}};
      op_r    <= 3'd0;
      a_r     <= {XLEN{1'b0}};
      b_r     <= {XLEN{1'b0}};
      cnt_r   <= CNT_ZERO;
      rem_r   <= {(XLEN+1){1'b0}};
      quo_r   <= {XLEN{1'b0}};
      dvs_r   <= {XLEN{1'b0}};
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      dz_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            op_r <= op;
            a_r  <= op1;
            b_r  <= op2;
            case (op)
              OP_MTHI: begin
                hi_r   <= op1;
                done_r <= 1'b1;
              end
              OP_MTLO: begin
                lo_r   <= op1;
                done_r <= 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                state_r <= DIV;
                busy_r  <= 1'b1;
                cnt_r   <= DIV_LOAD;
                dz_r    <= (op2 == {XLEN{1'b0}});
                rem_r   <= {(XLEN+1){1'b0}};
                quo_r   <= mag1_s;
                dvs_r   <= mag2_s;
                neg_q_r <= (op == OP_DIV) && (op1[XLEN-1] ^ op2[XLEN-1]);
                neg_r_r <= (op == OP_DIV) && op1[XLEN-1];
              end
              default: begin
                state_r <= MUL;
                busy_r  <= 1'b1;
                cnt_r   <= MUL_LOAD;
              end
            endcase
          end else begin
            busy_r <= 1'b0;
          end
        end
        MUL: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (cnt_r == CNT_ZERO) begin
            {hi_r, lo_r} <= mul_res_s;
            done_r       <= 1'b1;
            state_r      <= IDLE;
            busy_r       <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        DIV: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else if (dz_r) begin
            done_r  <= 1'b1;
            dbz_r   <= 1'b1;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            rem_r <= rem_step_s;
            quo_r <= quo_step_s;
            if (cnt_r == CNT_ZERO) begin
              state_r <= FIX;
            end else begin
              cnt_r <= cnt_r - CNT_W'(1);
            end
          end
        end
        FIX: begin
          if (abort) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            lo_r    <= quo_fix_s;
            hi_r    <= rem_fix_s;
            done_r  <= 1'b1;
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed testbench for muldiv_iter_unit (XLEN=32, MUL_CYCLES=4, DIV_BITS_PER_CYCLE=1).
module tb_muldiv_iter_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        abort;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic        rd_hi_sel;
  logic [31:0] rdata;

  int checks   = 0;
  int failures = 0;

  muldiv_iter_unit #(
    .XLEN(32),
    .MUL_CYCLES(4),
    .DIV_BITS_PER_CYCLE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .op1(op1),
    .op2(op2),
    .abort(abort),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .rd_hi_sel(rd_hi_sel),
    .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; afterwards the operand inputs are scrambled to prove capture at T0.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    op1   = a;
    op2   = b;
    step();
    start = 1'b0;
    op1   = ~a;
    op2   = ~b;
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    rd_hi_sel = 1'b1;
    #1;
    h = rdata;
    rd_hi_sel = 1'b0;
    #1;
    l = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] h, l;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got busy/done/dbz=%b exp=000", {busy, done, div_by_zero});
    end
    read_hilo(h, l);
    checks++;
    if ({h, l} !== 64'd0) begin
      failures++;
      $display("FAIL reset_hilo got HI=%h LO=%h exp 0/0", h, l);
    end
  endtask

  task automatic test_mult();
    logic [31:0] h, l;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        failures++;
        $display("FAIL mult_busy cycle=%0d got busy=%b done=%b exp 1/0", k, busy, done);
      end
      step();
    end
    checks++;
    if ({busy, done, div_by_zero} !== 3'b010) begin
      failures++;
      $display("FAIL mult_done got busy/done/dbz=%b exp=010", {busy, done, div_by_zero});
    end
    read_hilo(h, l);
    checks++;
    if ({h, l} !== 64'hFFFFFFFF_FFFFFFFA) begin
      failures++;
      $display("FAIL mult_result got HI=%h LO=%h exp FFFFFFFF/FFFFFFFA", h, l);
    end
    // back-to-back: MULTU launched in the MULT done cycle
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        failures++;
        $display("FAIL multu_busy cycle=%0d got busy=%b done=%b exp 1/0", k, busy, done);
      end
      step();
    end
    checks++;
    if ({busy, done} !== 2'b01) begin
      failures++;
      $display("FAIL multu_done got busy=%b done=%b exp 0/1", busy, done);
    end
    read_hilo(h, l);
    checks++;
    if ({h, l} !== 64'h00000002_FFFFFFFA) begin
      failures++;
      $display("FAIL multu_result got HI=%h LO=%h exp 00000002/FFFFFFFA", h, l);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL multu_done_pulse got done=%b exp 0", done);
    end
  endtask

  task automatic test_div();
    logic [2:0]  ops   [3] = '{3'd2, 3'd3, 3'd2};
    logic [31:0] dvd   [3] = '{32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    logic [31:0] dvs   [3] = '{32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] exp_l [3] = '{32'hFFFFFFFD, 32'h00000000, 32'h80000000};
    logic [31:0] exp_h [3] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    logic [31:0] h, l;
    for (int v = 0; v < 3; v++) begin
      issue(ops[v], dvd[v], dvs[v]);
      for (int k = 1; k <= 33; k++) begin
        checks++;
        if ({busy, done} !== 2'b10) begin
          failures++;
          $display("FAIL div_busy vec=%0d cycle=%0d got busy=%b done=%b exp 1/0", v, k, busy, done);
        end
        step();
      end
      checks++;
      if ({busy, done, div_by_zero} !== 3'b010) begin
        failures++;
        $display("FAIL div_done vec=%0d got busy/done/dbz=%b exp=010", v, {busy, done, div_by_zero});
      end
      read_hilo(h, l);
      checks++;
      if ({h, l} !== {exp_h[v], exp_l[v]}) begin
        failures++;
        $display("FAIL div_result vec=%0d got HI=%h LO=%h exp %h/%h", v, h, l, exp_h[v], exp_l[v]);
      end
    end
    step();
  endtask

  task automatic test_madd_msub();
    logic [31:0] h, l;
    issue(3'd5, 32'hFFFFFFFF, 32'd0);
    read_hilo(h, l);
    checks++;
    if ({busy, done, l} !== {2'b01, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL mtlo got busy=%b done=%b LO=%h exp 0/1/FFFFFFFF", busy, done, l);
    end
    issue(3'd4, 32'd0, 32'd0);
    read_hilo(h, l);
    checks++;
    if ({busy, done, h, l} !== {2'b01, 32'h00000000, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL mthi got busy=%b done=%b HI=%h LO=%h exp 0/1/00000000/FFFFFFFF", busy, done, h, l);
    end
    issue(3'd6, 32'd1, 32'd1);
    repeat (4) step();
    read_hilo(h, l);
    checks++;
    if ({done, h, l} !== {1'b1, 32'h00000001, 32'h00000000}) begin
      failures++;
      $display("FAIL madd got done=%b HI=%h LO=%h exp 1/00000001/00000000", done, h, l);
    end
    issue(3'd7, 32'd1, 32'd1);
    repeat (4) step();
    read_hilo(h, l);
    checks++;
    if ({done, h, l} !== {1'b1, 32'h00000000, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL msub got done=%b HI=%h LO=%h exp 1/00000000/FFFFFFFF", done, h, l);
    end
    step();
  endtask

  task automatic test_div_by_zero();
    logic [31:0] h, l;
    // abort while idle must not block a same-cycle start
    abort = 1'b1;
    issue(3'd5, 32'h00000022, 32'd0);
    abort = 1'b0;
    read_hilo(h, l);
    checks++;
    if ({done, l} !== {1'b1, 32'h00000022}) begin
      failures++;
      $display("FAIL idle_abort_start got done=%b LO=%h exp 1/00000022", done, l);
    end
    issue(3'd4, 32'h00000011, 32'd0);
    issue(3'd2, 32'd5, 32'd0);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b100) begin
      failures++;
      $display("FAIL dbz_busy got busy/done/dbz=%b exp=100", {busy, done, div_by_zero});
    end
    step();
    checks++;
    if ({busy, done, div_by_zero} !== 3'b011) begin
      failures++;
      $display("FAIL dbz_done got busy/done/dbz=%b exp=011", {busy, done, div_by_zero});
    end
    read_hilo(h, l);
    checks++;
    if ({h, l} !== {32'h00000011, 32'h00000022}) begin
      failures++;
      $display("FAIL dbz_hilo got HI=%h LO=%h exp 00000011/00000022", h, l);
    end
    step();
    checks++;
    if ({done, div_by_zero} !== 2'b00) begin
      failures++;
      $display("FAIL dbz_pulse got done/dbz=%b exp=00", {done, div_by_zero});
    end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] h, l;
    issue(3'd3, 32'd100, 32'd7);
    for (int k = 1; k <= 33; k++) begin
      if (k == 3) begin
        start = 1'b1;
        op    = 3'd0;
        op1   = 32'd9;
        op2   = 32'd9;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    read_hilo(h, l);
    checks++;
    if ({busy, done, h, l} !== {2'b01, 32'd2, 32'd14}) begin
      failures++;
      $display("FAIL start_while_busy got busy=%b done=%b HI=%h LO=%h exp 0/1/2/14", busy, done, h, l);
    end
    step();
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++;
      $display("FAIL ignored_start_launched got busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_abort();
    int          abort_at [2] = '{10, 33};
    logic [31:0] h, l;
    for (int v = 0; v < 2; v++) begin
      issue(3'd2, 32'd100, 32'd7);
      for (int k = 1; k <= abort_at[v]; k++) begin
        checks++;
        if ({busy, done} !== 2'b10) begin
          failures++;
          $display("FAIL abort_busy at=%0d cycle=%0d got busy=%b done=%b exp 1/0", abort_at[v], k, busy, done);
        end
        if (k == abort_at[v]) abort = 1'b1;
        else abort = 1'b0;
        step();
      end
      abort = 1'b0;
      checks++;
      if ({busy, done} !== 2'b00) begin
        failures++;
        $display("FAIL abort_idle at=%0d got busy=%b done=%b exp 0/0", abort_at[v], busy, done);
      end
      for (int k = 0; k < 3; k++) begin
        step();
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL abort_no_done at=%0d cycle=%0d got done=%b exp 0", abort_at[v], k, done);
        end
      end
      read_hilo(h, l);
      checks++;
      if ({h, l} !== {32'd2, 32'd14}) begin
        failures++;
        $display("FAIL abort_hilo at=%0d got HI=%h LO=%h exp 2/14", abort_at[v], h, l);
      end
    end
  endtask

  task automatic test_rst_mid();
    logic [31:0] h, l;
    issue(3'd0, 32'd7, 32'd6);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    read_hilo(h, l);
    checks++;
    if ({busy, done, h, l} !== {2'b00, 32'd0, 32'd0}) begin
      failures++;
      $display("FAIL rst_mid got busy=%b done=%b HI=%h LO=%h exp 0/0/0/0", busy, done, h, l);
    end
    issue(3'd0, 32'd7, 32'd6);
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        failures++;
        $display("FAIL rst_restart_busy cycle=%0d got busy=%b done=%b exp 1/0", k, busy, done);
      end
      step();
    end
    read_hilo(h, l);
    checks++;
    if ({done, h, l} !== {1'b1, 32'd0, 32'd42}) begin
      failures++;
      $display("FAIL rst_restart_result got done=%b HI=%h LO=%h exp 1/0/42", done, h, l);
    end
    step();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    op        = 3'd0;
    op1       = 32'd0;
    op2       = 32'd0;
    abort     = 1'b0;
    rd_hi_sel = 1'b0;
    test_reset();
    test_mult();
    test_div();
    test_madd_msub();
    test_div_by_zero();
    test_start_while_busy();
    test_abort();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised iterative multiply/divide engine that owns the architectural HI/LO pair.
- Sits behind the muldiv execution slots. A slot drives start/op/op1/op2 when it holds the muldiv lock, polls busy, and reads HI/LO through rd_hi_sel/rdata.
- Generalises the fixed 32-bit unit: configurable width, multiply latency and divider radix.
- Adds abort (squash on mispredict), MADD/MSUB accumulate, MTHI/MTLO and a divide-by-zero flag.

Parameters:
- XLEN, 32, operand and HI/LO width.
- MUL_CYCLES, 4, busy cycles for multiply-class ops (>=1).
- DIV_BITS_PER_CYCLE, 1, quotient bits retired per divide iteration (1, 2 or 4; must divide XLEN).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  launch op; accepted only when busy=0
- op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MSUB
- op1  in  XLEN  rs operand / dividend
- op2  in  XLEN  rt operand / divisor
- abort  in  1  squash in-flight op
- busy  out  1  op in flight
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  qualifies done
- rd_hi_sel  in  1  1 selects HI, 0 selects LO
- rdata  out  XLEN  selected HI/LO register

Behaviour:
- Decided: one clock; reset synchronous, active-high.
- Reset state: HI=LO=0, busy=0, done=0, div_by_zero=0, FSM=IDLE.
  - Reset mid-operation discards the op: no done, HI/LO cleared.
- FSM states: IDLE, MUL, DIV, FIX.
- start while busy=1 is ignored; operands and op are not re-latched.
- op1, op2 and op are captured at the accepting edge (T0). Inputs may change afterwards.
- MTHI/MTLO:
  - HI (or LO) := op1 at T0.
  - busy stays 0; done=1 in cycle T0+1.
- MULT/MULTU/MADD/MSUB:
  - IDLE->MUL; busy=1 for cycles T0+1..T0+MUL_CYCLES.
  - HI/LO written at the edge ending the last busy cycle; done=1 with busy=0 in cycle T0+MUL_CYCLES+1.
  - MULT: {HI,LO} := signed 2XLEN product. MULTU: unsigned product.
  - MADD: {HI,LO} := {HI,LO} + signed product. MSUB: {HI,LO} := {HI,LO} - signed product.
  - MADD/MSUB arithmetic is modulo 2^(2*XLEN); the accumulate operand is the HI/LO value at completion.
- DIV/DIVU:
  - op2==0: DIV state for exactly one busy cycle, then IDLE. HI/LO unchanged; done=1 and div_by_zero=1 in the same cycle.
  - Otherwise: latch |op1| and |op2| (raw values for DIVU) and run a restoring divider.
    - DIV state for XLEN/DIV_BITS_PER_CYCLE cycles, then FIX for one cycle.
    - busy total = XLEN/DIV_BITS_PER_CYCLE + 1 cycles.
  - FIX: for signed DIV, negate the quotient if the operand signs differ; the remainder takes the sign of op1. Write LO=quotient, HI=remainder.
  - Overflow: DIV of MIN by -1 yields LO=MIN, HI=0 (falls out of the unsigned datapath; no special case).
- abort:
  - While busy=1: FSM->IDLE at the next edge. busy=0 the following cycle; HI/LO unchanged; no done.
  - Abort beats completion in the final busy cycle.
  - While busy=0: ignored; a same-cycle start is accepted normally.
- done and div_by_zero are single-cycle pulses; div_by_zero=0 whenever done=0.
- rdata = rd_hi_sel ? HI : LO, combinational from the registers. A new value is visible in the cycle done rises; there is no operand bypass.
- Back-to-back: start may be asserted in the done cycle and is accepted.

Test Plan (XLEN=32, MUL_CYCLES=4, DIV_BITS_PER_CYCLE=1):
- MULT op1=0xFFFFFFFE, op2=3 -> busy 4 cycles; done in cycle 5; HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV op1=0xFFFFFFF9, op2=2 -> busy 33 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 0x80000000/0xFFFFFFFF -> LO=0, HI=0x80000000.
  - DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTLO 0xFFFFFFFF, MTHI 0, then MADD 1*1 -> HI=1, LO=0; then MSUB 1*1 -> HI=0, LO=0xFFFFFFFF.
- DIV op1=5, op2=0 with HI=0x11, LO=0x22 -> 1 busy cycle; done=div_by_zero=1; HI/LO unchanged.
- DIV started; abort in busy cycle 10 -> busy=0 next cycle, no done pulse, HI/LO unchanged.
  - Same with abort in busy cycle 33 -> still no done.
  - A start asserted while busy is ignored (result matches the original operands).
- rst asserted mid-MULT -> next cycle busy=0, HI=LO=0, no done.
  - start in the following cycle is accepted and completes normally.
